gcd_requester: RTL and testbench

Host-side initiator for the GCD engine's stream protocol. Accepts one operand pair per request from a host and packs it into the engine's 32-bit `{a,b}` input word. It then waits for the engine's result and returns it to the host through a valid/ready response channel. It handles zero operands locally, applies a response timeout, and keeps a completed-transaction count. It sits between a host or sequencer and the `GCD` engine: its `gcd_*` outputs drive the engine's input, and its `gcd_*` inputs take the engine's outputs.

---
 rtl/gcd_requester.sv | 144 ++++++++++++++
 tb/tb_gcd_requester.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_requester.sv
// Purpose : host-side initiator for the GCD engine: takes one {a,b} request, drives the
//           engine, waits for its result (or a timeout) and returns it to the host.
// Latency : zero-operand requests respond in the cycle after the request handshake;
//           otherwise 1 cycle to issue, then engine latency + 1, or TIMEOUT cycles of WAIT.
// Backpres: one transaction in flight; req_ready is low from acceptance until the
//           response handshake. Engine input is held stable until gcd_in_ready, and the
//           response is held stable until rsp_ready.
//
// Ports:
//   clk, rst         - clock (rising edge) and asynchronous active-low reset
//   req_*            - host request channel (valid/ready, operands a and b)
//   gcd_in_*         - engine input word {a,b}, with a in the upper half
//   gcd_out_*        - engine result (only looked at while waiting for it)
//   rsp_*            - host response channel (valid/ready, data, error flag)
//   busy, count      - not-idle flag, completed-response counter (wraps at 16 bits)
module gcd_requester #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               req_ready,
  output logic               gcd_in_valid,
  output logic [2*WIDTH-1:0] gcd_in_data,
  input  logic               gcd_in_ready,
  input  logic               gcd_out_valid,
  input  logic [WIDTH-1:0]   gcd_out_data,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_error,
  input  logic               rsp_ready,
  output logic               busy,
  output logic [15:0]        count
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             err_q, err_nxt;
  logic [TW-1:0]    tcnt_q, tcnt_nxt;
  logic [15:0]      cnt_q, cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      tcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      data_q <= data_nxt;
      err_q  <= err_nxt;
      tcnt_q <= tcnt_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    data_nxt  = data_q;
    err_nxt   = err_q;
    tcnt_nxt  = tcnt_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          a_nxt = req_a;
          b_nxt = req_b;
          if (req_a == '0 && req_b == '0) begin
            // gcd(0,0) is undefined: answer locally with an error
            data_nxt  = '0;
            err_nxt   = 1'b1;
            state_nxt = RESP;
          end else if (req_a == '0 || req_b == '0) begin
            // gcd(x,0) = x; the OR picks the nonzero operand
            data_nxt  = req_a | req_b;
            err_nxt   = 1'b0;
            state_nxt = RESP;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (gcd_in_ready) begin
          tcnt_nxt  = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        tcnt_nxt = tcnt_q + TW'(1);
        // a result arriving on the last allowed cycle still beats the timeout
        if (gcd_out_valid) begin
          data_nxt  = gcd_out_data;
          err_nxt   = 1'b0;
          state_nxt = RESP;
        end else if (tcnt_q == TLAST) begin
          data_nxt  = '0;
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          cnt_nxt   = cnt_q + 16'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state; nothing flows straight from inputs.
  assign req_ready    = (state == IDLE);
  assign gcd_in_valid = (state == ISSUE);
  assign gcd_in_data  = (state == ISSUE) ? {a_q, b_q} : '0;
  assign rsp_valid    = (state == RESP);
  assign rsp_data     = (state == RESP) ? data_q : '0;
  assign rsp_error    = (state == RESP) && err_q;
  assign busy         = (state != IDLE);
  assign count        = cnt_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Purpose : directed, table-driven bench for gcd_requester with a latency-programmable
//           behavioural GCD engine; TIMEOUT is set to 8.
// Ports   : none (top-level bench).
module tb_gcd_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_a, req_b;
  logic        req_ready;
  logic        gcd_in_valid;
  logic [31:0] gcd_in_data;
  logic        gcd_in_ready;
  logic        gcd_out_valid;
  logic [15:0] gcd_out_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic        rsp_ready;
  logic        busy;
  logic [15:0] count;

  always #5 clk = ~clk;

  gcd_requester #(.WIDTH(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .gcd_in_valid(gcd_in_valid), .gcd_in_data(gcd_in_data), .gcd_in_ready(gcd_in_ready),
    .gcd_out_valid(gcd_out_valid), .gcd_out_data(gcd_out_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .rsp_ready(rsp_ready),
    .busy(busy), .count(count)
  );

  // Behavioural engine: result valid for one cycle, eng_lat cycles after the
  // input handshake cycle; eng_lat = 0 means it never answers.
  int          eng_lat;
  int          eng_cnt;
  logic [15:0] eng_res;
  logic        man_ov;
  logic [15:0] man_dat;

  function automatic logic [15:0] gcd_f(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] t;
    while (y != 16'd0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_cnt <= 0;
      eng_res <= 16'd0;
    end else if (gcd_in_valid && gcd_in_ready && eng_lat > 0) begin
      eng_cnt <= eng_lat;
      eng_res <= gcd_f(gcd_in_data[31:16], gcd_in_data[15:0]);
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  assign gcd_out_valid = (eng_cnt == 1) || man_ov;
  assign gcd_out_data  = man_ov ? man_dat : eng_res;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          lat;   // engine latency, 0 = engine silent
    logic [15:0] data;
    logic        err;
    logic        used;  // engine input expected to be driven
    int          cyc;   // cycle in which rsp_valid first appears
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  int          exp_cnt;
  int          cyc;
  logic        saw;
  logic        got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    // a, b, lat, data, err, used, cyc
    vecs[0] = '{16'h0030, 16'h0020, 4, 16'h0010, 1'b0, 1'b1, 6};
    vecs[1] = '{16'h0007, 16'h0000, 4, 16'h0007, 1'b0, 1'b0, 1};
    vecs[2] = '{16'h0000, 16'h0000, 4, 16'h0000, 1'b1, 1'b0, 1};
    vecs[3] = '{16'h0000, 16'h0009, 4, 16'h0009, 1'b0, 1'b0, 1};
    vecs[4] = '{16'h0015, 16'h000E, 4, 16'h0007, 1'b0, 1'b1, 6};
    vecs[5] = '{16'hFFFF, 16'h0001, 7, 16'h0001, 1'b0, 1'b1, 9};
    vecs[6] = '{16'h1234, 16'h5678, 0, 16'h0000, 1'b1, 1'b1, 10};  // timeout
    vecs[7] = '{16'h0064, 16'h0019, 4, 16'h0019, 1'b0, 1'b1, 6};   // after timeout
    vecs[8] = '{16'h0048, 16'h0030, 8, 16'h0018, 1'b0, 1'b1, 10};  // result ties timeout

    rst = 1'b0;
    req_valid = 1'b0; req_a = '0; req_b = '0;
    gcd_in_ready = 1'b1; rsp_ready = 1'b1;
    man_ov = 1'b0; man_dat = '0; eng_lat = 4;
    exp_cnt = 0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_in_valid", {31'd0, gcd_in_valid}, 32'd0);
    chk("rst_in_data", gcd_in_data, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    step(); step();
    rst = 1'b1;
    step();

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      eng_lat = vecs[i].lat;
      req_a = vecs[i].a; req_b = vecs[i].b; req_valid = 1'b1;
      step();                     // handshake at end of cycle 0
      req_valid = 1'b0;
      cyc = 1; saw = 1'b0; got = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (cyc == 1 && vecs[i].used)
          chk($sformatf("v%0d_in_data_c1", i), gcd_in_data, {vecs[i].a, vecs[i].b});
        if (gcd_in_valid) saw = 1'b1;
        if (rsp_valid) begin
          got = 1'b1;
          break;
        end
        step();
        cyc++;
      end
      chk($sformatf("v%0d_rsp_seen", i), {31'd0, got}, 32'd1);
      chk($sformatf("v%0d_rsp_cycle", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_rsp_data", i), {16'd0, rsp_data}, {16'd0, vecs[i].data});
      chk($sformatf("v%0d_rsp_error", i), {31'd0, rsp_error}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_engine_used", i), {31'd0, saw}, {31'd0, vecs[i].used});
      exp_cnt++;
      step();                     // rsp_ready=1: handshake happened
      chk($sformatf("v%0d_count", i), {16'd0, count}, exp_cnt & 32'hFFFF);
      chk($sformatf("v%0d_req_ready_after", i), {31'd0, req_ready}, 32'd1);
    end

    // ---------------- engine backpressure ----------------
    eng_lat = 4;
    gcd_in_ready = 1'b0;
    req_a = 16'h0015; req_b = 16'h000E; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("bp_in_valid_%0d", j), {31'd0, gcd_in_valid}, 32'd1);
      chk($sformatf("bp_in_data_%0d", j), gcd_in_data, 32'h0015000E);
      step();
    end
    gcd_in_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("bp_rsp_seen", {31'd0, got}, 32'd1);
    chk("bp_rsp_data", {16'd0, rsp_data}, 32'h0007);
    chk("bp_rsp_error", {31'd0, rsp_error}, 32'd0);
    exp_cnt++;
    step();
    chk("bp_count", {16'd0, count}, exp_cnt & 32'hFFFF);

    // ---------------- response backpressure ----------------
    rsp_ready = 1'b0;
    req_a = 16'h0007; req_b = 16'h0000; req_valid = 1'b1;
    step();                       // cycle 1: RESP
    req_a = 16'h0000; req_b = 16'h0005;   // competing request kept valid
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("rbp_rsp_valid_%0d", j), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("rbp_rsp_data_%0d", j), {16'd0, rsp_data}, 32'h0007);
      chk($sformatf("rbp_req_ready_%0d", j), {31'd0, req_ready}, 32'd0);
      chk($sformatf("rbp_busy_%0d", j), {31'd0, busy}, 32'd1);
      step();
    end
    chk("rbp_rsp_data_c6", {16'd0, rsp_data}, 32'h0007);
    rsp_ready = 1'b1;             // handshake at end of cycle 6
    step();
    exp_cnt++;
    chk("rbp_rsp_valid_c7", {31'd0, rsp_valid}, 32'd0);
    chk("rbp_req_ready_c7", {31'd0, req_ready}, 32'd1);
    chk("rbp_count_c7", {16'd0, count}, exp_cnt & 32'hFFFF);
    step();                       // second request accepted at end of cycle 7
    req_valid = 1'b0;
    chk("rbp2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rbp2_rsp_data", {16'd0, rsp_data}, 32'h0005);
    chk("rbp2_rsp_error", {31'd0, rsp_error}, 32'd0);
    step();
    exp_cnt++;
    chk("rbp2_count", {16'd0, count}, exp_cnt & 32'hFFFF);

    // ---------------- reset mid-WAIT ----------------
    eng_lat = 0;
    req_a = 16'h0030; req_b = 16'h0020; req_valid = 1'b1;
    step();                       // cycle 1: ISSUE, accepted at end
    req_valid = 1'b0;
    step();                       // cycle 2: WAIT
    step();                       // cycle 3: WAIT
    chk("rw_busy_pre", {31'd0, busy}, 32'd1);
    chk("rw_in_valid_pre", {31'd0, gcd_in_valid}, 32'd0);
    #3;
    rst = 1'b0;
    #1;
    chk("rw_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rw_in_valid", {31'd0, gcd_in_valid}, 32'd0);
    chk("rw_in_data", gcd_in_data, 32'd0);
    chk("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rw_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rw_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_count", {16'd0, count}, 32'd0);
    step();
    rst = 1'b1;
    step();
    man_dat = 16'h1234; man_ov = 1'b1;
    step();
    man_ov = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("rw_late_rsp_valid_%0d", j), {31'd0, rsp_valid}, 32'd0);
      chk($sformatf("rw_late_busy_%0d", j), {31'd0, busy}, 32'd0);
      step();
    end
    chk("rw_late_count", {16'd0, count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
